life_engine_pp: RTL and testbench

//  Parametrised Life-like cellular automaton engine, successor to the fixed 64x64 B3/S23 core.

---
 rtl/life_engine_pp.sv | 199 +++++++++++++++++++
 tb/tb_life_engine_pp.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_engine_pp.sv
// life_engine_pp: Life-like cellular automaton on a 2**LOG_W x 2**LOG_H board.
// Two board banks alternate roles each generation: one is displayed and read
// for neighbour counts while the other receives the next generation, so no
// copy pass is needed. Run-time birth/survive masks, torus or dead edges,
// LFSR random fill and a single-cell write port.
// Optional feature: define LIFE_POPCOUNT_EN to add the o_population counter.
module life_engine_pp #(
    parameter int          LOG_W     = 6,
    parameter int          LOG_H     = 6,
    parameter int          GEN_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_step,
    input  logic             i_randomize,
    input  logic             i_clear,
    input  logic             i_wrap_en,
    input  logic [8:0]       i_birth_mask,
    input  logic [8:0]       i_survive_mask,
    input  logic             i_wr_en,
    input  logic [LOG_W-1:0] i_wr_x,
    input  logic [LOG_H-1:0] i_wr_y,
    input  logic             i_wr_data,
    input  logic [LOG_W-1:0] i_rd_x,
    input  logic [LOG_H-1:0] i_rd_y,
    output logic             o_rd_alive,
    output logic             o_busy,
    output logic             o_gen_done,
    output logic [GEN_W-1:0] o_generation
`ifdef LIFE_POPCOUNT_EN
    ,
    output logic [LOG_W+LOG_H:0] o_population
`endif
);
    localparam int IW = LOG_W + LOG_H;
    localparam int N  = 1 << IW;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_UPDATE, S_SWAP} state_t;

    state_t                 r_state, w_next;
    logic [1:0][N-1:0]      r_bank;
    logic                   r_cur;
    logic [IW-1:0]          r_idx;
    logic                   r_fill_clr;
    logic                   r_wrap;
    logic [8:0]             r_birth, r_survive;
    logic [GEN_W-1:0]       r_gen;
    logic                   r_gen_done;
    logic [15:0]            r_lfsr;

    logic                   w_idle, w_last;
    logic                   w_do_clear, w_do_rand, w_do_step, w_do_wr;
    logic [LOG_W-1:0]       w_x;
    logic [LOG_H-1:0]       w_y;
    logic [3:0]             w_cnt;
    logic                   w_self, w_rule, w_fill_bit;

    // Command decode; priority clear > randomize > step > write, IDLE only
    assign w_idle     = (r_state == S_IDLE);
    assign w_do_clear = w_idle & i_clear;
    assign w_do_rand  = w_idle & ~i_clear & i_randomize;
    assign w_do_step  = w_idle & ~i_clear & ~i_randomize & i_step;
    assign w_do_wr    = w_idle & ~i_clear & ~i_randomize & ~i_step & i_wr_en;
    assign w_last     = &r_idx;

    assign w_x        = r_idx[LOG_W-1:0];
    assign w_y        = r_idx[IW-1:LOG_W];
    assign w_self     = r_bank[r_cur][r_idx];
    assign w_rule     = w_self ? r_survive[w_cnt] : r_birth[w_cnt];
    assign w_fill_bit = r_fill_clr ? 1'b0 : r_lfsr[0];

    assign o_rd_alive   = r_bank[r_cur][{i_rd_y, i_rd_x}];
    assign o_busy       = ~w_idle;
    assign o_gen_done   = r_gen_done;
    assign o_generation = r_gen;

    // State register; reset starts a random fill
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_FILL;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_do_clear | w_do_rand) w_next = S_FILL;
                      else if (w_do_step)         w_next = S_UPDATE;
            S_FILL:   if (w_last) w_next = S_IDLE;
            S_UPDATE: if (w_last) w_next = S_SWAP;
            S_SWAP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // 3x3 neighbour count around r_idx in the displayed bank; index arithmetic
    // wraps mod W/H naturally, and edge neighbours are masked when not a torus
    always_comb begin : nbr
        logic [LOG_W-1:0] nx;
        logic [LOG_H-1:0] ny;
        logic             ok;
        w_cnt = '0;
        nx    = '0;
        ny    = '0;
        ok    = 1'b0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) begin
                    nx = w_x + LOG_W'(dx);
                    ny = w_y + LOG_H'(dy);
                    ok = r_wrap || !((dx == -1 && w_x == '0) || (dx == 1 && (&w_x)) ||
                                     (dy == -1 && w_y == '0) || (dy == 1 && (&w_y)));
                    w_cnt = w_cnt + 4'(ok & r_bank[r_cur][{ny, nx}]);
                end
            end
        end
    end

    // Board storage: fill and writes hit the displayed bank, updates the other
    always_ff @(posedge i_clk) begin
        if (r_state == S_FILL)        r_bank[r_cur][r_idx]            <= w_fill_bit;
        else if (r_state == S_UPDATE) r_bank[!r_cur][r_idx]           <= w_rule;
        else if (w_do_wr)             r_bank[r_cur][{i_wr_y, i_wr_x}] <= i_wr_data;
    end

    // Sequencing: cell index, bank select, latched rule, generation, done pulse
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx      <= '0;
            r_cur      <= 1'b0;
            r_fill_clr <= 1'b0;
            r_wrap     <= 1'b0;
            r_birth    <= '0;
            r_survive  <= '0;
            r_gen      <= '0;
            r_gen_done <= 1'b0;
        end else begin
            r_gen_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (w_do_clear | w_do_rand) r_fill_clr <= w_do_clear;
                    if (w_do_step) begin
                        r_wrap    <= i_wrap_en;
                        r_birth   <= i_birth_mask;
                        r_survive <= i_survive_mask;
                    end
                end
                S_FILL: begin
                    r_idx <= r_idx + 1'b1;
                    if (w_last) begin
                        r_gen      <= '0;
                        r_gen_done <= 1'b1;
                    end
                end
                S_UPDATE: r_idx <= r_idx + 1'b1;
                S_SWAP: begin
                    r_cur      <= ~r_cur;
                    r_gen      <= r_gen + 1'b1;
                    r_gen_done <= 1'b1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

    // Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_lfsr <= LFSR_SEED;
        else         r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

`ifdef LIFE_POPCOUNT_EN
    logic [IW:0] r_pop, r_acc, w_acc_next;
    logic        w_cell_bit, w_wr_old;

    assign w_cell_bit   = (r_state == S_FILL) ? w_fill_bit : w_rule;
    assign w_acc_next   = ((r_idx == '0) ? '0 : r_acc) + (IW+1)'(w_cell_bit);
    assign w_wr_old     = r_bank[r_cur][{i_wr_y, i_wr_x}];
    assign o_population = r_pop;

    // Live-cell count: accumulate over a pass, publish at its end, track writes
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pop <= '0;
            r_acc <= '0;
        end else if (r_state == S_FILL || r_state == S_UPDATE) begin
            r_acc <= w_acc_next;
            if (r_state == S_FILL && w_last) r_pop <= w_acc_next;
        end else if (r_state == S_SWAP) begin
            r_pop <= r_acc;
        end else if (w_do_wr && (i_wr_data != w_wr_old)) begin
            r_pop <= i_wr_data ? r_pop + 1'b1 : r_pop - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_life_engine_pp.sv
`timescale 1ns/1ps
module tb_life_engine_pp;
    localparam logic [8:0]  B3   = 9'h008;
    localparam logic [8:0]  S23  = 9'h00C;
    localparam logic [63:0] HORZ = 64'h0000_0000_1C00_0000; // (2,3),(3,3),(4,3)
    localparam logic [63:0] VERT = 64'h0000_0008_0808_0000; // (3,2),(3,3),(3,4)
    localparam logic [63:0] EDGE = 64'h0000_0000_0000_0083; // (7,0),(0,0),(1,0)
    localparam logic [63:0] EDGV = 64'h0100_0000_0000_0101; // (0,7),(0,0),(0,1)
    localparam logic [63:0] GLID = 64'h0000_0000_0007_0402; // glider

    logic        clk = 1'b0, reset = 1'b1;
    logic        step = 0, randomize = 0, clear = 0, wrap_en = 1, wr_en = 0, wr_data = 0;
    logic [8:0]  birth_mask = B3, survive_mask = S23;
    logic [2:0]  wr_x = 0, wr_y = 0, rd_x = 0, rd_y = 0;
    logic        rd_alive, busy, gen_done;
    logic [15:0] generation;
`ifdef LIFE_POPCOUNT_EN
    logic [6:0]  population;
`endif

    typedef struct { logic [63:0] board; int gen; int pop; } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    life_engine_pp #(.LOG_W(3), .LOG_H(3), .GEN_W(16), .LFSR_SEED(16'h0001)) dut (
        .i_clk(clk), .i_reset(reset), .i_step(step), .i_randomize(randomize), .i_clear(clear),
        .i_wrap_en(wrap_en), .i_birth_mask(birth_mask), .i_survive_mask(survive_mask),
        .i_wr_en(wr_en), .i_wr_x(wr_x), .i_wr_y(wr_y), .i_wr_data(wr_data),
        .i_rd_x(rd_x), .i_rd_y(rd_y), .o_rd_alive(rd_alive), .o_busy(busy),
        .o_gen_done(gen_done), .o_generation(generation)
`ifdef LIFE_POPCOUNT_EN
        , .o_population(population)
`endif
    );

    always #5 clk = ~clk;

    // Reference next generation on an 8x8 board
    function automatic logic [63:0] life_next(input logic [63:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm, input logic wr);
        logic [63:0] n;
        int cnt, xx, yy;
        n = '0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++) begin
                cnt = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx == 0 && dy == 0) continue;
                        xx = x + dx; yy = y + dy;
                        if (wr) begin xx = (xx + 8) % 8; yy = (yy + 8) % 8; end
                        else if (xx < 0 || xx > 7 || yy < 0 || yy > 7) continue;
                        cnt += int'(b[yy*8+xx]);
                    end
                n[y*8+x] = b[y*8+x] ? sm[cnt] : bm[cnt];
            end
        return n;
    endfunction

    // Board produced by a random fill starting from the reset seed
    function automatic logic [63:0] seed_fill();
        logic [63:0] b;
        logic [15:0] s;
        s = 16'h0001;
        for (int i = 0; i < 64; i++) begin
            b[i] = s[0];
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return b;
    endfunction

    task automatic read_board(output logic [63:0] b);
        for (int i = 0; i < 64; i++) begin
            rd_x = i[2:0]; rd_y = i[5:3];
            #1 b[i] = rd_alive;
        end
    endtask

    // Counts clock edges until gen_done; commands are dropped after the first edge
    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 1) begin step = 0; randomize = 0; clear = 0; wr_en = 0; end
        end while (!gen_done && n < max);
        if (!gen_done) n = -1;
    endtask

    task automatic cmd(input logic s, input logic r, input logic c, output int n);
        @(negedge clk);
        step = s; randomize = r; clear = c;
        wait_done(200, n);
    endtask

    task automatic write_cell(input int x, input int y, input logic d);
        @(negedge clk);
        wr_en = 1; wr_x = x[2:0]; wr_y = y[2:0]; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    task automatic pop_and_read(output exp_t e, output logic [63:0] got);
        if (q.size() == 0) begin
            e.board = 'x; e.gen = -1; e.pop = -1;
        end else e = q.pop_front();
        read_board(got);
    endtask

    task automatic test_reset;
        exp_t e; logic [63:0] got; int bad;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b exp 1", busy); end
        checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL reset_gen_done: got %b exp 0", gen_done); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL reset_generation: got %0d exp 0", generation); end
`ifdef LIFE_POPCOUNT_EN
        checks++; if (population !== 7'd0) begin errors++; $display("FAIL reset_population: got %0d exp 0", population); end
`endif
        q.push_back('{seed_fill(), 0, $countones(seed_fill())});
        @(negedge clk); reset = 0;
        bad = 0;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (n < 64 && (busy !== 1'b1 || gen_done !== 1'b0)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_busy_window: %0d bad cycles exp 0", bad); end
        checks++; if (busy !== 1'b0 || gen_done !== 1'b1) begin errors++; $display("FAIL fill_done_cycle65: busy=%b done=%b exp 0/1", busy, gen_done); end
        @(posedge clk); #1;
        checks++; if (gen_done !== 1'b0) begin errors++; $display("FAIL fill_done_pulse: got %b exp 0", gen_done); end
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL fill_board: got %h exp %h", got, e.board); end
        checks++; if (generation !== 16'(e.gen)) begin errors++; $display("FAIL fill_generation: got %0d exp %0d", generation, e.gen); end
`ifdef LIFE_POPCOUNT_EN
        checks++; if (population !== 7'(e.pop)) begin errors++; $display("FAIL fill_population: got %0d exp %0d", population, e.pop); end
`endif
    endtask

    task automatic test_blinker;
        exp_t e; logic [63:0] got; int n;
        cmd(0, 0, 1, n);
        checks++; if (n != 65) begin errors++; $display("FAIL clear_latency: got %0d exp 65", n); end
        rd_x = 3; rd_y = 3;
        #1;
        checks++; if (rd_alive !== 1'b0) begin errors++; $display("FAIL clear_cell: got %b exp 0", rd_alive); end
        write_cell(3, 3, 1);
        checks++; if (rd_alive !== 1'b1) begin errors++; $display("FAIL write_visible: got %b exp 1", rd_alive); end
        write_cell(2, 3, 1); write_cell(4, 3, 1);
        wrap_en = 1;
        q.push_back('{VERT, 1, 3});
        cmd(1, 0, 0, n);
        checks++; if (n != 66) begin errors++; $display("FAIL step_latency: got %0d exp 66", n); end
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL blinker_vert: got %h exp %h", got, e.board); end
        q.push_back('{HORZ, 2, 3});
        cmd(1, 0, 0, n);
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL blinker_horz: got %h exp %h", got, e.board); end
        checks++; if (generation !== 16'(e.gen)) begin errors++; $display("FAIL blinker_gen: got %0d exp %0d", generation, e.gen); end
`ifdef LIFE_POPCOUNT_EN
        checks++; if (population !== 7'(e.pop)) begin errors++; $display("FAIL blinker_pop: got %0d exp %0d", population, e.pop); end
`endif
    endtask

    task automatic test_edges;
        exp_t e; logic [63:0] got; int n;
        for (int w = 1; w >= 0; w--) begin
            cmd(0, 0, 1, n);
            write_cell(7, 0, 1); write_cell(0, 0, 1); write_cell(1, 0, 1);
            wrap_en = w[0];
            q.push_back('{(w == 1) ? EDGV : 64'h0, 1, (w == 1) ? 3 : 0});
            cmd(1, 0, 0, n);
            wrap_en = 1;
            pop_and_read(e, got);
            checks++; if (got !== e.board) begin errors++; $display("FAIL edge_wrap%0d: got %h exp %h", w, got, e.board); end
`ifdef LIFE_POPCOUNT_EN
            checks++; if (population !== 7'(e.pop)) begin errors++; $display("FAIL edge_pop%0d: got %0d exp %0d", w, population, e.pop); end
`endif
        end
    endtask

    task automatic test_glider;
        exp_t e; logic [63:0] got, m; int n, bad;
        cmd(0, 0, 1, n);
        write_cell(1, 0, 1); write_cell(2, 1, 1); write_cell(0, 2, 1);
        write_cell(1, 2, 1); write_cell(2, 2, 1);
        wrap_en = 1;
        m = GLID; bad = 0;
        for (int g = 1; g <= 32; g++) begin
            m = life_next(m, B3, S23, 1'b1);
            q.push_back('{m, g, $countones(m)});
            cmd(1, 0, 0, n);
            pop_and_read(e, got);
            if (n != 66 || got !== e.board || generation !== 16'(e.gen)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glider_steps: %0d bad generations exp 0", bad); end
        checks++; if (got !== GLID) begin errors++; $display("FAIL glider_restored: got %h exp %h", got, GLID); end
        checks++; if (generation !== 16'd32) begin errors++; $display("FAIL glider_gen: got %0d exp 32", generation); end
    endtask

    task automatic test_priority_ignore;
        exp_t e; logic [63:0] got; int n, pulses, unstable;
        write_cell(5, 5, 1);
        q.push_back('{64'h0, 0, 0});
        cmd(1, 1, 1, n);
        checks++; if (n != 65) begin errors++; $display("FAIL prio_latency: got %0d exp 65", n); end
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL prio_clear_board: got %h exp %h", got, e.board); end
        checks++; if (generation !== 16'(e.gen)) begin errors++; $display("FAIL prio_clear_gen: got %0d exp %0d", generation, e.gen); end
        write_cell(2, 3, 1); write_cell(3, 3, 1); write_cell(4, 3, 1);
        rd_x = 2; rd_y = 3;
        q.push_back('{VERT, 1, 3});
        @(negedge clk); step = 1;
        pulses = 0; unstable = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            step = (c == 10);
            if (gen_done) pulses++;
            if (busy && rd_alive !== 1'b1) unstable++;
        end
        step = 0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_step_pulses: got %0d exp 1", pulses); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL rd_stable_update: %0d bad cycles exp 0", unstable); end
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL ignore_board: got %h exp %h", got, e.board); end
        checks++; if (generation !== 16'(e.gen)) begin errors++; $display("FAIL ignore_gen: got %0d exp %0d", generation, e.gen); end
    endtask

    task automatic test_reset_mid;
        exp_t e; logic [63:0] got; int early;
        @(negedge clk); step = 1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk); #1; step = 0;
        end
        @(negedge clk); reset = 1;
        #1;
        checks++; if (busy !== 1'b1 || gen_done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: busy=%b done=%b exp 1/0", busy, gen_done); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL mid_reset_gen: got %0d exp 0", generation); end
        q.push_back('{seed_fill(), 0, $countones(seed_fill())});
        repeat (2) @(negedge clk);
        reset = 0;
        early = 0;
        for (int c = 1; c < 64; c++) begin
            @(posedge clk); #1;
            if (gen_done || !busy) early++;
        end
        @(posedge clk); #1;
        checks++; if (early != 0) begin errors++; $display("FAIL mid_reset_early: %0d bad cycles exp 0", early); end
        checks++; if (gen_done !== 1'b1) begin errors++; $display("FAIL mid_reset_done: got %b exp 1", gen_done); end
        pop_and_read(e, got);
        checks++; if (got !== e.board) begin errors++; $display("FAIL mid_reset_board: got %h exp %h", got, e.board); end
        checks++; if (generation !== 16'(e.gen)) begin errors++; $display("FAIL mid_reset_gen_end: got %0d exp %0d", generation, e.gen); end
`ifdef LIFE_POPCOUNT_EN
        checks++; if (population !== 7'(e.pop)) begin errors++; $display("FAIL mid_reset_pop: got %0d exp %0d", population, e.pop); end
`endif
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_edges();
        test_glider();
        test_priority_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
